// File: rtl/key_seq_generator.sv
// key_seq_generator: serial MSB-first pattern transmitter paced by pulse_p.
// Optional KEY_SEQ_LOOP_EN adds a stop input for continuous replay.
module key_seq_generator #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_p,
  input  logic             start,
`ifdef KEY_SEQ_LOOP_EN
  input  logic             stop,
`endif
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] last;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] idx_m1;
  logic             wrap;

  // bit select via shift keeps the index width independent of PAT_W
  function automatic logic pick(
    input logic [PAT_W-1:0] v,
    input logic [LEN_W-1:0] i
  );
    logic [PAT_W-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // clamp requested length to the pattern register width
  always_comb begin
    len_eff = len_in;
    if (len_in > PAT_LEN)
      len_eff = PAT_LEN;
    len_m1 = len_eff - ONE;
    idx_m1 = idx - ONE;
  end

  // replay decision taken at the strobe that consumes bit 0
`ifdef KEY_SEQ_LOOP_EN
  assign wrap = !stop;
`else
  assign wrap = 1'b0;
`endif

  // sequencer: state, latched pattern, index and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat       <= '0;
      idx       <= '0;
      last      <= '0;
      key_out   <= 1'b0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && (len_eff != '0)) begin
            pat       <= pattern_in;
            idx       <= len_m1;
            last      <= len_m1;
            key_out   <= pick(pattern_in, len_m1);
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          done <= 1'b0;
          if (pulse_p) begin
            if (idx != '0) begin
              idx     <= idx_m1;
              key_out <= pick(pat, idx_m1);
            end else if (wrap) begin
              done    <= 1'b1;
              idx     <= last;
              key_out <= pick(pat, last);
            end else begin
              key_out   <= 1'b0;
              key_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/key_seq_generator.md
Name: key_seq_generator

Overview:
- Serial pattern transmitter: the driving end of the key-sequence detector interface.
- Captures a pattern word and a bit length on `start`, then presents the pattern MSB-first on `key_out`, one bit per `pulse_p` sample strobe.
- Sits upstream of the detector FSM and shares its `clk` and `pulse_p` enable. Used for self-test and for stimulus generation on the board.

Parameters:
- PAT_W, 8, width of the pattern register (maximum sequence length in bits).
- LEN_W, 4, width of `len_in`; must hold the value PAT_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- pulse_p  input  1  one-cycle sample strobe shared with the consumer; the bit on `key_out` is consumed in any cycle where `pulse_p`=1.
- start  input  1  request to begin a sequence; sampled only in IDLE.
- pattern_in  input  PAT_W  pattern source; bit `len-1` is sent first, bit 0 last.
- len_in  input  LEN_W  number of bits to send.
- key_out  output  1  serial bit presented to the consumer; registered.
- key_valid  output  1  high while `key_out` carries a pattern bit; registered.
- busy  output  1  high from the cycle after `start` is accepted until return to IDLE.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset: synchronous. `rst_n`=0 at a clk edge forces state=IDLE and `key_out`=0, `key_valid`=0, `busy`=0, `done`=0, shift register=0, bit index=0. This applies at any point, including mid-sequence: the sequence is aborted and no `done` is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 with an effective length L≥1: latch `pattern_in`, set index=L-1, go to SHIFT.
  - In that same edge: `key_out` <= `pattern_in[L-1]`, `key_valid` <= 1, `busy` <= 1.
  - The first bit is therefore visible one cycle after `start`.
- Effective length: L = `len_in` if `len_in`≤PAT_W, else L = PAT_W (clamped).
  - `len_in`=0: `start` is ignored; stay in IDLE; all outputs remain 0.
- `pulse_p` coincident with accepted `start`: no bit is consumed, because `key_out` is not yet valid. The first consumed bit is at the first `pulse_p` after entry to SHIFT.
- SHIFT:
  - `pulse_p`=0: hold everything.
  - `pulse_p`=1 and index>0: index <= index-1; `key_out` <= latched bit[index-1].
  - `pulse_p`=1 and index=0: go to DONE; `key_out` <= 0, `key_valid` <= 0, `done` <= 1.
- DONE: lasts exactly one cycle with `done`=1. Next edge: `done` <= 0, `busy` <= 0, go to IDLE.
- `start` asserted while in SHIFT or DONE: ignored. The pattern is not re-latched and no queuing occurs.
- Changes to `pattern_in`/`len_in` after acceptance have no effect.
- Latency:
  - `start` accepted → `key_valid`=1 next cycle.
  - Total: L `pulse_p` strobes + 1 cycle to `done`, + 1 cycle to `busy`=0.
- `key_out` is stable between strobes; it changes only on the clk edge of a cycle in which `pulse_p`=1. This lets a consumer that samples `key` combinationally on `pulse_p` see each bit exactly once.

Optional Feature:
- Macro: KEY_SEQ_LOOP_EN.
- Defined:
  - Extra input port `stop` (1 bit) is present.
  - On the strobe consuming bit 0 with `stop`=0: `done` pulses for one cycle while the FSM stays in SHIFT. Index reloads to L-1 and `key_out` <= latched bit[L-1]; `key_valid` stays 1.
  - `stop` is sampled only at that strobe. With `stop`=1 the FSM proceeds to DONE as in single-shot mode. `stop` elsewhere is ignored.
- Undefined: no `stop` port; single-shot behaviour exactly as above.

Test Plan:
- Reset: hold `rst_n`=0 for 3 clks → `key_out`=0, `key_valid`=0, `busy`=0, `done`=0, FSM in IDLE.
- Basic sequence: `pattern_in`=8'h0D, `len_in`=4, `start` 1 clk, `pulse_p` every 4th clk.
  - `key_out` presented at strobes: 1,1,0,1.
  - `key_valid` high for exactly that window.
  - `done` pulses once, 1 clk after the 4th strobe; `busy` falls the cycle after.
- End-to-end: pair with the detector FSM driven by the same `pulse_p` and `pattern_in`=8'h0D, `len_in`=4 → detector `result`=1 during the 4th strobe cycle only.
- Boundaries:
  - `len_in`=0 with `start` → `busy` stays 0, no `done`.
  - `len_in`=12 with `pattern_in`=8'hA5 → 8 bits sent: 1,0,1,0,0,1,0,1.
- Overlap and abort:
  - `start` pulsed during SHIFT with a different pattern → original sequence completes unchanged.
  - `rst_n`=0 after the 2nd strobe → outputs 0 next clk, no `done`, and a new `start` is accepted afterwards.
- Loop mode (KEY_SEQ_LOOP_EN): `pattern_in`=8'h03, `len_in`=2, `stop`=0 → `key_out` 1,1,1,1… with `done` pulsing every 2nd strobe. Raise `stop` before a final bit → exactly one more `done`, then IDLE.
